mist_frame_trigger: RTL and testbench

Synthesizable source of the frame count and waveform-dump trigger that the simulation dump monitor consumes. It sits beside the video timing in the MiST test harness, counts frames on falling edges of vertical sync, tracks the ROM download strobe, and produces a gated dump window, so the dump monitor and any on-chip logic analyser share one cycle-exact trigger point. It also drives frame-count and dump-state observability into the test top.

---
 rtl/mist_frame_trigger.sv | 131 +++++++++++++
 tb/tb_mist_frame_trigger.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mist_frame_trigger.sv
// Frame counter and dump-window trigger for the MiST simulation harness.
// Counts vertical-sync falls and opens a dump window on a frame number or a ROM download end.
module mist_frame_trigger #(
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned DUMP_FRAMES = 0,
  parameter int unsigned LOADROM     = 0,
  parameter int unsigned SETTLE      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_vs,
  input  logic        led,
  output logic [31:0] frame_cnt,
  output logic        dump_en,
  output logic        dump_start,
  output logic        dump_stop,
  output logic [2:0]  st
);

  typedef enum logic [2:0] {
    StSettle = 3'd0,
    StWaitDl = 3'd1,
    StWaitFr = 3'd2,
    StDump   = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam bit          LoadRom    = (LOADROM != 0);
  localparam logic [15:0] SettleLast = (SETTLE == 0) ? 16'd0 : 16'(SETTLE - 1);
  localparam logic [31:0] StartFrame = 32'(START_FRAME);
  localparam logic [31:0] DumpLast   = (DUMP_FRAMES == 0) ? 32'd0 : 32'(DUMP_FRAMES - 1);

  logic [1:0]  vs_sync_q, vs_sync_d, led_sync_q, led_sync_d;
  logic        vs_prev_q, vs_prev_d, led_prev_q, led_prev_d;
  logic        vs_fall_q, vs_fall_d, led_fall_q, led_fall_d, led_rise_q, led_rise_d;
  state_e      state_q, state_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] len_cnt_q, len_cnt_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic        dump_start_q, dump_start_d, dump_stop_q, dump_stop_d;

  // Bit 1 is the second synchronizer stage; edges are registered so they last one full cycle.
  always_comb begin
    vs_sync_d  = {vs_sync_q[0], vga_vs};
    led_sync_d = {led_sync_q[0], led};
    vs_prev_d  = vs_sync_q[1];
    led_prev_d = led_sync_q[1];
    vs_fall_d  = vs_prev_q & ~vs_sync_q[1];
    led_fall_d = led_prev_q & ~led_sync_q[1];
    led_rise_d = ~led_prev_q & led_sync_q[1];
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    len_cnt_d    = len_cnt_q;
    settle_cnt_d = settle_cnt_q;
    if (vs_fall_q) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
    case (state_q)
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d = LoadRom ? StWaitDl : StWaitFr;
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
      StWaitDl: if (led_fall_q) state_d = StDump;
      StWaitFr: if (vs_fall_q && frame_cnt_q == StartFrame) state_d = StDump;
      StDump: begin
        // A new download takes priority over a window close on the same cycle.
        if (LoadRom && led_rise_q) begin
          state_d = StWaitDl;
        end else if (vs_fall_q) begin
          if (DUMP_FRAMES != 0 && len_cnt_q == DumpLast) begin
            state_d = StDone;
          end else begin
            len_cnt_d = len_cnt_q + 32'd1;
          end
        end
      end
      StDone:  if (LoadRom && led_rise_q) state_d = StWaitDl;
      default: state_d = StSettle;
    endcase
    if (state_d == StDump && state_q != StDump) begin
      len_cnt_d = 32'd0;
    end
    dump_start_d = (state_d == StDump) && (state_q != StDump);
    dump_stop_d  = (state_q == StDump) && (state_d != StDump);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync_q    <= 2'b00;
      led_sync_q   <= 2'b00;
      vs_prev_q    <= 1'b0;
      led_prev_q   <= 1'b0;
      vs_fall_q    <= 1'b0;
      led_fall_q   <= 1'b0;
      led_rise_q   <= 1'b0;
      state_q      <= StSettle;
      frame_cnt_q  <= 32'd0;
      len_cnt_q    <= 32'd0;
      settle_cnt_q <= 16'd0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
    end else begin
      vs_sync_q    <= vs_sync_d;
      led_sync_q   <= led_sync_d;
      vs_prev_q    <= vs_prev_d;
      led_prev_q   <= led_prev_d;
      vs_fall_q    <= vs_fall_d;
      led_fall_q   <= led_fall_d;
      led_rise_q   <= led_rise_d;
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      len_cnt_q    <= len_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      dump_start_q <= dump_start_d;
      dump_stop_q  <= dump_stop_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign dump_en    = (state_q == StDump);
  assign dump_start = dump_start_q;
  assign dump_stop  = dump_stop_q;
  assign st         = state_q;

endmodule

// File: tb/tb_mist_frame_trigger.sv
// Bench for mist_frame_trigger: three configurations share stimulus and are checked every cycle
// against a cycle-indexed reference model, plus table rows and directed corner sequences.
module tb_mist_frame_trigger;

  localparam int MaxCyc = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vga_vs = 1'b0;
  logic led = 1'b0;

  logic [31:0] fc [3];
  logic        en [3];
  logic        start [3];
  logic        stop [3];
  logic [2:0]  st [3];

  int n_cmp = 0;
  int n_fail = 0;
  int start_cnt [3] = '{0, 0, 0};
  int stop_cnt [3] = '{0, 0, 0};
  bit checking = 1'b0;
  bit force_req = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: frame trigger. 1: download trigger, open-ended. 2: download trigger, 2 frames.
  mist_frame_trigger #(.START_FRAME(3), .DUMP_FRAMES(2), .LOADROM(0), .SETTLE(20)) u_fr (
    .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs), .led(led), .frame_cnt(fc[0]), .dump_en(en[0]),
    .dump_start(start[0]), .dump_stop(stop[0]), .st(st[0]));
  mist_frame_trigger #(.START_FRAME(0), .DUMP_FRAMES(0), .LOADROM(1), .SETTLE(20)) u_dl (
    .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs), .led(led), .frame_cnt(fc[1]), .dump_en(en[1]),
    .dump_start(start[1]), .dump_stop(stop[1]), .st(st[1]));
  mist_frame_trigger #(.START_FRAME(0), .DUMP_FRAMES(2), .LOADROM(1), .SETTLE(5)) u_rs (
    .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs), .led(led), .frame_cnt(fc[2]), .dump_en(en[2]),
    .dump_start(start[2]), .dump_stop(stop[2]), .st(st[2]));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] fc;
    logic [31:0] len;
    logic [15:0] sc;
    logic        start;
    logic        stop;
  } mdl_t;

  mdl_t m [3];
  bit   vs_h [MaxCyc];
  bit   led_h [MaxCyc];
  int   ncyc = 0;

  // Pad value sampled at clock edge k since reset; before reset everything reads as 0.
  function automatic bit vs_at(int k);
    return (k < 0) ? 1'b0 : vs_h[k];
  endfunction
  function automatic bit led_at(int k);
    return (k < 0) ? 1'b0 : led_h[k];
  endfunction

  function automatic mdl_t step(mdl_t c, int idx, bit vf, bit lf, bit lr);
    int unsigned sf, df, ld, stl;
    mdl_t n;
    case (idx)
      0:       begin sf = 3; df = 2; ld = 0; stl = 20; end
      1:       begin sf = 0; df = 0; ld = 1; stl = 20; end
      default: begin sf = 0; df = 2; ld = 1; stl = 5;  end
    endcase
    n = c;
    n.start = 1'b0;
    n.stop = 1'b0;
    if (vf) n.fc = c.fc + 1;
    if (c.st == 3'd0) begin
      if (stl == 0 || int'(c.sc) == int'(stl) - 1) n.st = (ld != 0) ? 3'd1 : 3'd2;
      else n.sc = c.sc + 1;
    end else if (c.st == 3'd1) begin
      if (lf) n.st = 3'd3;
    end else if (c.st == 3'd2) begin
      if (vf && c.fc == 32'(sf)) n.st = 3'd3;
    end else if (c.st == 3'd3) begin
      if (ld != 0 && lr) n.st = 3'd1;
      else if (vf && df != 0 && c.len + 1 == 32'(df)) n.st = 3'd4;
      else if (vf) n.len = c.len + 1;
    end else begin
      if (ld != 0 && lr) n.st = 3'd1;
    end
    if (n.st == 3'd3 && c.st != 3'd3) begin
      n.start = 1'b1;
      n.len = 0;
    end
    if (c.st == 3'd3 && n.st != 3'd3) n.stop = 1'b1;
    return n;
  endfunction

  // A pad edge reaches the state register on the 4th clock edge after it is sampled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncyc <= 0;
      for (int i = 0; i < 3; i++) m[i] <= '0;
    end else begin
      vs_h[ncyc] <= vga_vs;
      led_h[ncyc] <= led;
      for (int i = 0; i < 3; i++) begin
        mdl_t nx;
        nx = step(m[i], i, vs_at(ncyc - 4) & ~vs_at(ncyc - 3),
                  led_at(ncyc - 4) & ~led_at(ncyc - 3), ~led_at(ncyc - 4) & led_at(ncyc - 3));
        if (i == 0 && force_req) nx.fc = 32'hFFFF_FFFF;
        m[i] <= nx;
      end
      if (ncyc < MaxCyc - 1) ncyc <= ncyc + 1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [37:0] act, exp;
      if (start[i]) start_cnt[i]++;
      if (stop[i]) stop_cnt[i]++;
      if (checking) begin
        act = {fc[i], en[i], start[i], stop[i], st[i]};
        exp = {m[i].fc, (m[i].st == 3'd3), m[i].start, m[i].stop, m[i].st};
        n_cmp++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL model_cmp inst%0d t=%0t: got fc=%0h en=%b start=%b stop=%b st=%0d, expected fc=%0h en=%b start=%b stop=%b st=%0d",
                   i, $time, act[37:6], act[5], act[4], act[3], act[2:0],
                   exp[37:6], exp[5], exp[4], exp[3], exp[2:0]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit l, input int hold);
    vga_vs = v;
    led = l;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          vs;
    bit          led;
    int          hold;
    logic [31:0] fc;
    logic [2:0]  st_fr;
    logic [2:0]  st_dl;
  } vec_t;

  vec_t tv [8];
  int start_before, stop_before;

  initial begin
    tv[0] = '{vs: 0, led: 0, hold: 4,  fc: 0, st_fr: 0, st_dl: 0};
    tv[1] = '{vs: 0, led: 1, hold: 4,  fc: 0, st_fr: 0, st_dl: 0};
    tv[2] = '{vs: 0, led: 0, hold: 6,  fc: 0, st_fr: 0, st_dl: 0};
    tv[3] = '{vs: 0, led: 0, hold: 10, fc: 0, st_fr: 2, st_dl: 1};
    tv[4] = '{vs: 1, led: 0, hold: 3,  fc: 0, st_fr: 2, st_dl: 1};
    tv[5] = '{vs: 0, led: 0, hold: 5,  fc: 1, st_fr: 2, st_dl: 1};
    tv[6] = '{vs: 1, led: 0, hold: 3,  fc: 1, st_fr: 2, st_dl: 1};
    tv[7] = '{vs: 0, led: 0, hold: 5,  fc: 2, st_fr: 2, st_dl: 1};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_fc%0d", i), fc[i], 32'd0);
      chk($sformatf("reset_flags%0d", i), {29'd0, en[i], start[i], stop[i]}, 32'd0);
      chk($sformatf("reset_st%0d", i), {29'd0, st[i]}, 32'd0);
    end
    checking = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Settle, ignored download edge, frame counting.
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].vs, tv[i].led, tv[i].hold);
      chk($sformatf("tv%0d_fc_fr", i), fc[0], tv[i].fc);
      chk($sformatf("tv%0d_fc_dl", i), fc[1], tv[i].fc);
      chk($sformatf("tv%0d_st_fr", i), {29'd0, st[0]}, {29'd0, tv[i].st_fr});
      chk($sformatf("tv%0d_st_dl", i), {29'd0, st[1]}, {29'd0, tv[i].st_dl});
      chk($sformatf("tv%0d_en", i), {30'd0, en[0], en[1]}, 32'd0);
    end

    // Wrap-around of the frame counter.
    start_before = start_cnt[0];
    force_req = 1'b1;
    @(posedge clk);
    #1;
    force u_fr.frame_cnt_q = 32'hFFFF_FFFF;
    force_req = 1'b0;
    @(posedge clk);
    #1;
    release u_fr.frame_cnt_q;
    chk("wrap_preset", fc[0], 32'hFFFF_FFFF);
    drive(1, 0, 3);
    drive(0, 0, 6);
    chk("wrap_zero", fc[0], 32'd0);
    chk("wrap_no_start", start_cnt[0], start_before);
    chk("wrap_st", {29'd0, st[0]}, 32'd2);

    // Frame trigger: frames 1..3, then the fall carrying frame 3 opens the window.
    repeat (3) begin
      drive(1, 0, 3);
      drive(0, 0, 6);
    end
    chk("fr_fc3", fc[0], 32'd3);
    drive(1, 0, 3);
    drive(0, 0, 3);
    chk("fr_start_early", {31'd0, start[0]}, 32'd0);
    drive(0, 0, 1);
    chk("fr_start", {31'd0, start[0]}, 32'd1);
    chk("fr_en_open", {31'd0, en[0]}, 32'd1);
    chk("fr_fc4", fc[0], 32'd4);
    drive(0, 0, 1);
    chk("fr_start_1cyc", {31'd0, start[0]}, 32'd0);
    drive(0, 0, 3);
    drive(1, 0, 3);
    drive(0, 0, 6);
    chk("fr_en_frame1", {31'd0, en[0]}, 32'd1);
    drive(1, 0, 3);
    drive(0, 0, 6);
    chk("fr_done_st", {29'd0, st[0]}, 32'd4);
    chk("fr_done_en", {31'd0, en[0]}, 32'd0);
    chk("fr_stop_once", stop_cnt[0], 32'd1);
    chk("dl_frames9", fc[1], 32'd9);

    // Download trigger on the end of the led strobe.
    drive(0, 1, 150);
    drive(0, 0, 3);
    chk("dl_start_early", {31'd0, start[1]}, 32'd0);
    drive(0, 0, 1);
    chk("dl_start", {31'd0, start[1]}, 32'd1);
    chk("dl_st_dump", {29'd0, st[1]}, 32'd3);
    drive(0, 0, 3);
    repeat (3) begin
      drive(1, 0, 3);
      drive(0, 0, 6);
    end
    chk("dl_en_open", {31'd0, en[1]}, 32'd1);

    // Download restart inside the open window.
    drive(0, 1, 3);
    chk("rs_stop_early", {31'd0, stop[1]}, 32'd0);
    drive(0, 1, 1);
    chk("rs_stop", {31'd0, stop[1]}, 32'd1);
    chk("rs_st", {29'd0, st[1]}, 32'd1);
    chk("rs_en", {31'd0, en[1]}, 32'd0);
    drive(0, 1, 1);
    chk("rs_stop_1cyc", {31'd0, stop[1]}, 32'd0);
    drive(0, 1, 20);
    drive(0, 0, 4);
    chk("rs_start_again", {31'd0, start[1]}, 32'd1);
    drive(0, 0, 3);

    // Asynchronous reset in the middle of an open window.
    chk("rst_pre_en", {31'd0, en[1]}, 32'd1);
    stop_before = stop_cnt[1];
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_fc", fc[1], 32'd0);
    chk("rst_flags", {29'd0, en[1], start[1], stop[1]}, 32'd0);
    chk("rst_st", {29'd0, st[1]}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_no_stop", stop_cnt[1], stop_before);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 2);
    chk("rst_after_st", {29'd0, st[1]}, 32'd0);
    chk("rst_after_fc", fc[1], 32'd0);

    // Random traffic on both pads, checked every cycle by the model.
    repeat (300) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 15)));
    end
    drive(0, 0, 8);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
